// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: widths, reset/NOP constants, fetch FSM encoding,
// IF/ID payload layout and the word-alignment helper.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    // S_REQ: free to issue a fetch; S_WAIT: exactly one fetch outstanding
    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    // One IF/ID buffer entry
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifid_entry_t;

    // Force an address onto a 4-byte instruction boundary
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_buffer.sv
// One-entry IF/ID register with valid/ready drain toward decode and a flush input.
// Ports:
//   clk, reset     clock and synchronous active-low reset
//   load           capture load_entry this edge (only asserted when the slot is free or draining)
//   load_entry     instruction word and its PC
//   flush          discard the held entry (wins over load)
//   out_ready      decode consumes the entry this cycle
//   out_valid      entry held (registered)
//   out_entry      held instruction and PC (registered)
module ifid_buffer
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  ifid_entry_t load_entry,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output ifid_entry_t out_entry
);

    // Valid bit: flush > load > drain; the payload only changes on load
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_entry <= '{instr: NOP_INSTR, pc: '0};
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_entry <= load_entry;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: closes the PC loop, issues one word fetch at a time to
// instruction memory and hands fetched words to decode through a one-entry IF/ID buffer.
// Ports:
//   clk, reset                      clock and synchronous active-low reset
//   pc_current / pc_next            PC register loop; pc_next is combinational
//   imem_req_valid/ready/addr       fetch request channel (valid and addr combinational)
//   imem_rsp_valid/data             fetch response, one per accepted request
//   redirect_valid/target           taken branch/jump: flush and restart at target
//   ifid_valid/ready/instr/pc       IF/ID buffer toward decode (registered)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = rv32i_pkg::RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = rv32i_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            ifid_valid,
    input  logic            ifid_ready,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc
);

    import rv32i_pkg::*;

    fetch_state_t    state, state_next;
    logic            kill, kill_next;
    logic [XLEN-1:0] req_pc, req_pc_next;
    logic            slot_free;
    logic            buf_load;
    logic            buf_flush;
    ifid_entry_t     buf_in;
    ifid_entry_t     buf_out;

    // A fetch may only go out if its word is guaranteed a place in the buffer on return
    assign slot_free     = !ifid_valid || ifid_ready;
    assign imem_req_addr = word_align(pc_current);

    // State register; kill marks an outstanding fetch whose word must be discarded
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_REQ;
            kill   <= 1'b0;
            req_pc <= '0;
        end else begin
            state  <= state_next;
            kill   <= kill_next;
            req_pc <= req_pc_next;
        end
    end

    // Next-state, next-PC mux and request/buffer control
    always_comb begin
        state_next     = state;
        kill_next      = kill;
        req_pc_next    = req_pc;
        pc_next        = pc_current;
        imem_req_valid = 1'b0;
        buf_load       = 1'b0;
        buf_flush      = 1'b0;

        if (!reset) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            // Redirect beats everything; an in-flight fetch is either dropped now or marked
            pc_next   = word_align(redirect_target);
            buf_flush = 1'b1;
            if (state == S_WAIT) begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                    kill_next  = 1'b0;
                end else begin
                    kill_next  = 1'b1;
                end
            end
        end else begin
            unique case (state)
                S_REQ: begin
                    imem_req_valid = slot_free;
                    if (slot_free && imem_req_ready) begin
                        req_pc_next = pc_current;
                        pc_next     = XLEN'(pc_current + PC_STEP);
                        state_next  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_next = S_REQ;
                        if (kill) begin
                            kill_next = 1'b0;
                        end else begin
                            buf_load = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end
    end

    assign buf_in = '{instr: imem_rsp_data, pc: req_pc};

    ifid_buffer u_ifid_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .load_entry (buf_in),
        .flush      (buf_flush),
        .out_ready  (ifid_ready),
        .out_valid  (ifid_valid),
        .out_entry  (buf_out)
    );

    assign ifid_instr = buf_out.instr;
    assign ifid_pc    = buf_out.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, hand-written corner sequences, then
// randomized traffic checked against a program-order fetch/delivery model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_current = 32'h0;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    // The PC register that the fetch unit drives
    always @(posedge clk) pc_current <= pc_next;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_current      (pc_current),
        .pc_next         (pc_next),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_ready      (ifid_ready),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc)
    );

    typedef struct {
        logic        rst;
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        rd_v;
        logic [31:0] rd_t;
        logic        id_rdy;
        logic        e_rqv;
        logic [31:0] e_pcn;
        logic [31:0] e_addr;
        logic        chk_buf;
        logic        e_idv;
        logic [31:0] e_idpc;
        logic        chk_instr;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vq[$];

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1357;
    endfunction

    function automatic vec_t mk(input logic [31:0] rst, rq_rdy, rsp_v, rsp_d, rd_v, rd_t, id_rdy,
                                input logic [31:0] e_rqv, e_pcn, e_addr, chk_buf, e_idv, e_idpc,
                                input logic [31:0] chk_instr, e_instr);
        vec_t v;
        v.rst = rst[0];       v.rq_rdy = rq_rdy[0]; v.rsp_v = rsp_v[0]; v.rsp_d = rsp_d;
        v.rd_v = rd_v[0];     v.rd_t = rd_t;        v.id_rdy = id_rdy[0];
        v.e_rqv = e_rqv[0];   v.e_pcn = e_pcn;      v.e_addr = e_addr;
        v.chk_buf = chk_buf[0]; v.e_idv = e_idv[0]; v.e_idpc = e_idpc;
        v.chk_instr = chk_instr[0]; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge, return at the falling edge
    task automatic drv(input logic [31:0] r, qr, sv, sd, dv, dt, ir);
        @(posedge clk);
        #1;
        reset           = r[0];
        imem_req_ready  = qr[0];
        imem_rsp_valid  = sv[0];
        imem_rsp_data   = sd;
        redirect_valid  = dv[0];
        redirect_target = dt;
        ifid_ready      = ir[0];
        @(negedge clk);
    endtask

    vec_t        t;
    logic        pending;
    int unsigned delay;
    logic [31:0] pend_addr;
    logic [31:0] fetch_pc;
    logic [31:0] cons_pc;
    int unsigned consumed;
    logic        prev_redir;
    logic        rq, idr, rv, rsp;
    logic [31:0] tgt;

    initial begin
        reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_target = '0; ifid_ready = 1'b1;

        // rst rdy rspv rspd          rdv rdt     idr | rqv pcn     addr    cb idv idpc    ci instr
        vq.push_back(mk(0,1,0,0,              0,0,      1,  0,0,      0,      0, 0,0,      0,0));
        vq.push_back(mk(0,1,0,0,              0,0,      1,  0,0,      0,      1, 0,0,      1,NOP));
        vq.push_back(mk(1,1,0,0,              0,0,      1,  1,4,      0,      1, 0,0,      0,0));
        vq.push_back(mk(1,1,1,mem_word(0),    0,0,      1,  0,4,      4,      1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      1,  1,8,      4,      1, 1,0,      1,mem_word(0)));
        vq.push_back(mk(1,1,1,mem_word(4),    0,0,      1,  0,8,      8,      1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      0,  0,8,      8,      1, 1,4,      1,mem_word(4)));
        vq.push_back(mk(1,1,0,0,              0,0,      0,  0,8,      8,      1, 1,4,      1,mem_word(4)));
        vq.push_back(mk(1,1,0,0,              0,0,      1,  1,12,     8,      1, 1,4,      1,mem_word(4)));
        vq.push_back(mk(1,1,0,0,              1,'h100,  1,  0,'h100,  12,     1, 0,0,      0,0));
        vq.push_back(mk(1,1,1,mem_word(8),    0,0,      1,  0,'h100,  'h100,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      1,  1,'h104,  'h100,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,1,mem_word('h100),0,0,      1,  0,'h104,  'h104,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      0,  0,'h104,  'h104,  1, 1,'h100,  1,mem_word('h100)));
        vq.push_back(mk(1,1,0,0,              1,'h203,  0,  0,'h200,  'h104,  1, 1,'h100,  1,mem_word('h100)));
        vq.push_back(mk(1,0,0,0,              0,0,      0,  1,'h200,  'h200,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      0,  1,'h204,  'h200,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,1,mem_word('h200),0,0,      0,  0,'h204,  'h204,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      1,  1,'h208,  'h204,  1, 1,'h200,  1,mem_word('h200)));
        vq.push_back(mk(1,1,1,mem_word('h204),1,'h300,  1,  0,'h300,  'h208,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      1,  1,'h304,  'h300,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,1,mem_word('h300),0,0,      0,  0,'h304,  'h304,  1, 0,0,      0,0));
        vq.push_back(mk(1,1,0,0,              0,0,      0,  0,'h304,  'h304,  1, 1,'h300,  1,mem_word('h300)));
        vq.push_back(mk(1,1,1,'hBAD0_BAD0,    0,0,      0,  0,'h304,  'h304,  1, 1,'h300,  1,mem_word('h300)));
        vq.push_back(mk(1,1,0,0,              0,0,      0,  0,'h304,  'h304,  1, 1,'h300,  1,mem_word('h300)));

        for (int i = 0; i < vq.size(); i++) begin
            t = vq[i];
            drv(32'(t.rst), 32'(t.rq_rdy), 32'(t.rsp_v), t.rsp_d, 32'(t.rd_v), t.rd_t, 32'(t.id_rdy));
            chk1($sformatf("v%0d_req_valid", i), imem_req_valid, t.e_rqv);
            chk($sformatf("v%0d_pc_next", i), pc_next, t.e_pcn);
            chk($sformatf("v%0d_req_addr", i), imem_req_addr, t.e_addr);
            if (t.chk_buf) chk1($sformatf("v%0d_ifid_valid", i), ifid_valid, t.e_idv);
            if (t.chk_buf && t.e_idv) chk($sformatf("v%0d_ifid_pc", i), ifid_pc, t.e_idpc);
            if (t.chk_instr) chk($sformatf("v%0d_ifid_instr", i), ifid_instr, t.e_instr);
        end

        // Top-of-address-space wrap
        drv(1,1,0,0,1,32'hFFFF_FFFF,0);
        chk("wrap_redir_pc_next", pc_next, 32'hFFFF_FFFC);
        chk1("wrap_redir_no_req", imem_req_valid, 1'b0);
        drv(1,1,0,0,0,0,0);
        chk1("wrap_req_valid", imem_req_valid, 1'b1);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0);
        drv(1,1,1,mem_word(32'hFFFF_FFFC),0,0,0);
        chk("wrap_wait_pc_next", pc_next, 32'h0);
        drv(1,1,0,0,0,0,0);
        chk1("wrap_ifid_valid", ifid_valid, 1'b1);
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_instr", ifid_instr, mem_word(32'hFFFF_FFFC));

        // Back-to-back redirects while a fetch is outstanding: last target wins, stale word dropped
        drv(1,1,0,0,0,0,1);
        chk("b2b_issue_addr", imem_req_addr, 32'h0);
        drv(1,1,0,0,1,'h400,1);
        chk("b2b_first_pc_next", pc_next, 32'h400);
        drv(1,1,0,0,1,'h500,1);
        chk("b2b_second_pc_next", pc_next, 32'h500);
        chk1("b2b_no_req", imem_req_valid, 1'b0);
        drv(1,1,1,mem_word(0),0,0,1);
        chk1("b2b_stale_no_req", imem_req_valid, 1'b0);
        drv(1,1,0,0,0,0,1);
        chk1("b2b_stale_dropped", ifid_valid, 1'b0);
        chk("b2b_restart_addr", imem_req_addr, 32'h500);
        drv(1,1,1,mem_word('h500),0,0,0);
        drv(1,1,0,0,0,0,0);
        chk1("b2b_ifid_valid", ifid_valid, 1'b1);
        chk("b2b_ifid_pc", ifid_pc, 32'h500);

        // Reset while waiting on memory: late response must not surface
        drv(1,1,0,0,0,0,1);
        chk("rstw_issue_addr", imem_req_addr, 32'h504);
        drv(0,1,0,0,0,0,1);
        chk("rstw_pc_next", pc_next, 32'h0);
        chk1("rstw_no_req", imem_req_valid, 1'b0);
        drv(1,0,1,mem_word('h504),0,0,1);
        chk1("rstw_late_dropped", ifid_valid, 1'b0);
        chk("rstw_restart_addr", imem_req_addr, 32'h0);
        drv(1,1,0,0,0,0,1);
        chk1("rstw_still_empty", ifid_valid, 1'b0);
        chk("rstw_pc_next_inc", pc_next, 32'h4);
        drv(1,1,1,mem_word(0),0,0,0);
        drv(1,1,0,0,0,0,0);
        chk("rstw_ifid_pc", ifid_pc, 32'h0);
        chk("rstw_ifid_instr", ifid_instr, mem_word(0));

        // Randomized traffic against a program-order model
        drv(0,1,0,0,0,0,1);
        pending = 1'b0; delay = 0; pend_addr = '0; fetch_pc = 32'h0; cons_pc = 32'h0;
        consumed = 0; prev_redir = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rq  = ($urandom_range(0, 3) != 0);
            idr = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            rsp = pending && (delay == 0);
            drv(1, 32'(rq), 32'(rsp), rsp ? mem_word(pend_addr) : 32'($urandom), 32'(rv), tgt, 32'(idr));

            if (prev_redir) chk1("rnd_post_redirect_empty", ifid_valid, 1'b0);
            if (rv) begin
                chk1("rnd_redirect_no_req", imem_req_valid, 1'b0);
                chk("rnd_redirect_pc_next", pc_next, tgt & ~32'h3);
            end else begin
                chk1("rnd_issue_rule", imem_req_valid, !pending && (!ifid_valid || idr));
                if (imem_req_valid) begin
                    chk("rnd_fetch_addr", imem_req_addr, fetch_pc);
                    chk("rnd_pc_next", pc_next, rq ? fetch_pc + 32'h4 : pc_current);
                end else begin
                    chk("rnd_pc_hold", pc_next, pc_current);
                end
                if (ifid_valid && idr) begin
                    chk("rnd_deliver_pc", ifid_pc, cons_pc);
                    chk("rnd_deliver_instr", ifid_instr, mem_word(cons_pc));
                    cons_pc  = cons_pc + 32'h4;
                    consumed++;
                end
            end

            if (rsp) pending = 1'b0;
            else if (pending) delay--;
            if (!rv && imem_req_valid && rq) begin
                pending   = 1'b1;
                delay     = $urandom_range(0, 3);
                pend_addr = imem_req_addr;
            end
            if (rv) begin
                fetch_pc = tgt & ~32'h3;
                cons_pc  = tgt & ~32'h3;
            end else if (imem_req_valid && rq) begin
                fetch_pc = fetch_pc + 32'h4;
            end
            prev_redir = rv;
        end
        chk1("rnd_progress", consumed >= 200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
